// File: rtl/line_xfer_ctrl.sv
// Line transfer controller: optional victim writeback through a write manager,
// then a line fill through a read manager, with a bounded wait on each finish.
module line_xfer_ctrl #(
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         miss_req,
   input  logic [31:0]  miss_addr,
   input  logic         wb_dirty,
   input  logic [31:0]  wb_addr,
   input  logic [127:0] wb_data,
   output logic         busy,
   output logic         fill_valid,
   output logic [127:0] fill_data,
   output logic         err,
   output logic         wstart_rq,
   output logic [31:0]  win_addr,
   output logic [127:0] in_wdata,
   input  logic         finish_wresp,
   output logic         rstart_rq,
   output logic [31:0]  rin_addr,
   input  logic [127:0] rdat_m_data,
   input  logic         rdat_m_valid,
   input  logic         finish_mrd
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB_REQ  = 3'd1,
      WB_WAIT = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    fill_addr_q, fill_addr_d;
   logic [31:0]    win_addr_q, win_addr_d;
   logic [127:0]   in_wdata_q, in_wdata_d;
   logic [127:0]   fill_data_q, fill_data_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           seen_q, seen_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic           wstart_q, wstart_d;
   logic           rstart_q, rstart_d;
   logic           fill_valid_q, fill_valid_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      win_addr_d  = win_addr_q;
      in_wdata_d  = in_wdata_q;
      fill_data_d = fill_data_q;
      cnt_d       = cnt_q;
      seen_d      = seen_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (miss_req) begin
               fill_addr_d = miss_addr & LINE_MASK;
               win_addr_d  = wb_addr & LINE_MASK;
               in_wdata_d  = wb_data;
               err_d       = 1'b0;
               if (wb_dirty) begin
                  state_d = WB_REQ;
               end else begin
                  state_d = RD_REQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WB_REQ: begin
            cnt_d   = {CW{1'b0}};
            state_d = WB_WAIT;
         end
         WB_WAIT: begin
            // A finish in the timeout cycle still wins
            if (finish_wresp) begin
               state_d = RD_REQ;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         RD_REQ: begin
            cnt_d   = {CW{1'b0}};
            seen_d  = 1'b0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (rdat_m_valid) begin
               fill_data_d = rdat_m_data;
               seen_d      = 1'b1;
            end else begin
               seen_d = seen_q;
            end
            if (finish_mrd) begin
               if (seen_q || rdat_m_valid) begin
                  state_d = DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d       = (state_d != IDLE);
      wstart_d     = (state_d == WB_REQ);
      rstart_d     = (state_d == RD_REQ);
      fill_valid_d = (state_d == DONE);
   end

   // State, latched line data, wait counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fill_addr_q  <= 32'd0;
         win_addr_q   <= 32'd0;
         in_wdata_q   <= 128'd0;
         fill_data_q  <= 128'd0;
         cnt_q        <= {CW{1'b0}};
         seen_q       <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         wstart_q     <= 1'b0;
         rstart_q     <= 1'b0;
         fill_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_addr_q  <= fill_addr_d;
         win_addr_q   <= win_addr_d;
         in_wdata_q   <= in_wdata_d;
         fill_data_q  <= fill_data_d;
         cnt_q        <= cnt_d;
         seen_q       <= seen_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         wstart_q     <= wstart_d;
         rstart_q     <= rstart_d;
         fill_valid_q <= fill_valid_d;
      end
   end

   assign busy       = busy_q;
   assign fill_valid = fill_valid_q;
   assign fill_data  = fill_data_q;
   assign err        = err_q;
   assign wstart_rq  = wstart_q;
   assign win_addr   = win_addr_q;
   assign in_wdata   = in_wdata_q;
   assign rstart_rq  = rstart_q;
   assign rin_addr   = fill_addr_q;

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Directed self-checking bench for line_xfer_ctrl (TIMEOUT=16).
module tb_line_xfer_ctrl;

   logic         clk;
   logic         rst_n;
   logic         miss_req;
   logic [31:0]  miss_addr;
   logic         wb_dirty;
   logic [31:0]  wb_addr;
   logic [127:0] wb_data;
   logic         busy;
   logic         fill_valid;
   logic [127:0] fill_data;
   logic         err;
   logic         wstart_rq;
   logic [31:0]  win_addr;
   logic [127:0] in_wdata;
   logic         finish_wresp;
   logic         rstart_rq;
   logic [31:0]  rin_addr;
   logic [127:0] rdat_m_data;
   logic         rdat_m_valid;
   logic         finish_mrd;

   int errors = 0;
   int checks = 0;
   int wst_cnt = 0;
   int rst_cnt = 0;
   int fv_cnt = 0;

   localparam logic [127:0] DATA_A5 = {16{8'hA5}};
   localparam logic [127:0] DATA_X  = 128'h01234567_89abcdef_fedcba98_76543210;
   localparam logic [127:0] DATA_Y  = 128'h55555555_66666666_77777777_88888888;
   localparam logic [127:0] WB_DAT  = 128'h44444444_33333333_22222222_11111111;

   line_xfer_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
      .wb_dirty(wb_dirty), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy),
      .fill_valid(fill_valid), .fill_data(fill_data), .err(err),
      .wstart_rq(wstart_rq), .win_addr(win_addr), .in_wdata(in_wdata),
      .finish_wresp(finish_wresp), .rstart_rq(rstart_rq), .rin_addr(rin_addr),
      .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (wstart_rq) wst_cnt <= wst_cnt + 1;
      if (rstart_rq) rst_cnt <= rst_cnt + 1;
      if (fill_valid) fv_cnt <= fv_cnt + 1;
      if ((wstart_rq && rstart_rq) || (wstart_rq && fill_valid) || (rstart_rq && fill_valid)) begin
         errors <= errors + 1;
         $display("FAIL pulse_overlap: wstart=%b rstart=%b fill_valid=%b, required at most one high",
                  wstart_rq, rstart_rq, fill_valid);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; miss_req = 1'b0; miss_addr = 32'd0; wb_dirty = 1'b0; wb_addr = 32'd0;
      wb_data = 128'd0; finish_wresp = 1'b0; rdat_m_data = 128'd0; rdat_m_valid = 1'b0;
      finish_mrd = 1'b0;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL reset_fill_valid: got %b expected 0", fill_valid); end
      checks++; if (fill_data !== 128'd0) begin errors++; $display("FAIL reset_fill_data: got %h expected 0", fill_data); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if ({wstart_rq, rstart_rq} !== 2'b00) begin errors++; $display("FAIL reset_starts: got %b expected 00", {wstart_rq, rstart_rq}); end
      checks++; if ({win_addr, rin_addr} !== 64'd0) begin errors++; $display("FAIL reset_addrs: got %h expected 0", {win_addr, rin_addr}); end
      checks++; if (in_wdata !== 128'd0) begin errors++; $display("FAIL reset_in_wdata: got %h expected 0", in_wdata); end
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_clean_miss();
      int w0, r0, f0;
      w0 = wst_cnt; r0 = rst_cnt; f0 = fv_cnt;
      miss_req = 1'b1; miss_addr = 32'h0000_1237; wb_dirty = 1'b0; wb_addr = 32'h1111_2222;
      step();
      miss_req = 1'b0;
      checks++; if (rstart_rq !== 1'b1) begin errors++; $display("FAIL clean_rstart_cycle1: got %b expected 1", rstart_rq); end
      checks++; if (rin_addr !== 32'h0000_1230) begin errors++; $display("FAIL clean_rin_addr: got %h expected 00001230", rin_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy: got %b expected 1", busy); end
      step();
      rdat_m_valid = 1'b1; rdat_m_data = DATA_A5;
      step();
      rdat_m_valid = 1'b0; rdat_m_data = 128'd0;
      checks++; if (fill_data !== DATA_A5) begin errors++; $display("FAIL clean_fill_data_load: got %h expected %h", fill_data, DATA_A5); end
      checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL clean_fill_valid_early: got %b expected 0", fill_valid); end
      finish_mrd = 1'b1;
      step();
      finish_mrd = 1'b0;
      checks++; if (fill_valid !== 1'b1) begin errors++; $display("FAIL clean_fill_valid: got %b expected 1", fill_valid); end
      checks++; if (fill_data !== DATA_A5) begin errors++; $display("FAIL clean_fill_data: got %h expected %h", fill_data, DATA_A5); end
      step();
      checks++; if ({busy, fill_valid} !== 2'b00) begin errors++; $display("FAIL clean_back_idle: got busy,fv=%b expected 00", {busy, fill_valid}); end
      step();
      checks++; if (wst_cnt - w0 !== 0) begin errors++; $display("FAIL clean_wstart_count: got %0d expected 0", wst_cnt - w0); end
      checks++; if (rst_cnt - r0 !== 1) begin errors++; $display("FAIL clean_rstart_count: got %0d expected 1", rst_cnt - r0); end
      checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL clean_fv_count: got %0d expected 1", fv_cnt - f0); end
   endtask

   task automatic test_dirty_miss();
      int w0, r0, f0;
      w0 = wst_cnt; r0 = rst_cnt; f0 = fv_cnt;
      miss_req = 1'b1; miss_addr = 32'h0000_4568; wb_dirty = 1'b1;
      wb_addr = 32'hdeadbeef; wb_data = WB_DAT;
      step();
      miss_req = 1'b0; wb_addr = 32'h0; wb_data = 128'd0;
      checks++; if (wstart_rq !== 1'b1) begin errors++; $display("FAIL dirty_wstart: got %b expected 1", wstart_rq); end
      checks++; if (win_addr !== 32'hdeadbee0) begin errors++; $display("FAIL dirty_win_addr: got %h expected deadbee0", win_addr); end
      checks++; if (in_wdata !== WB_DAT) begin errors++; $display("FAIL dirty_in_wdata: got %h expected %h", in_wdata, WB_DAT); end
      checks++; if (rstart_rq !== 1'b0) begin errors++; $display("FAIL dirty_rstart_early: got %b expected 0", rstart_rq); end
      step();
      // WB_WAIT cycle 1: a second miss_req that must be ignored
      miss_req = 1'b1; miss_addr = 32'h0000_9990; wb_addr = 32'h0bad_0bad; wb_data = DATA_Y;
      step();
      miss_req = 1'b0;
      step();
      finish_mrd = 1'b1;
      step();
      finish_mrd = 1'b0;
      step(); step(); step();
      finish_wresp = 1'b1;
      step();
      finish_wresp = 1'b0;
      checks++; if (rstart_rq !== 1'b1) begin errors++; $display("FAIL dirty_rstart_after_wresp: got %b expected 1", rstart_rq); end
      checks++; if (rin_addr !== 32'h0000_4560) begin errors++; $display("FAIL dirty_rin_addr: got %h expected 00004560", rin_addr); end
      checks++; if (win_addr !== 32'hdeadbee0) begin errors++; $display("FAIL busy_reject_win_addr: got %h expected deadbee0", win_addr); end
      step();
      rdat_m_valid = 1'b1; rdat_m_data = DATA_X; finish_mrd = 1'b1;
      step();
      rdat_m_valid = 1'b0; rdat_m_data = 128'd0; finish_mrd = 1'b0;
      checks++; if (fill_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_beat_fv: got %b expected 1", fill_valid); end
      checks++; if (fill_data !== DATA_X) begin errors++; $display("FAIL same_cycle_beat_data: got %h expected %h", fill_data, DATA_X); end
      step(); step();
      checks++; if (wst_cnt - w0 !== 1) begin errors++; $display("FAIL busy_reject_wstart_count: got %0d expected 1", wst_cnt - w0); end
      checks++; if (rst_cnt - r0 !== 1) begin errors++; $display("FAIL busy_reject_rstart_count: got %0d expected 1", rst_cnt - r0); end
      checks++; if (fv_cnt - f0 !== 1) begin errors++; $display("FAIL dirty_fv_count: got %0d expected 1", fv_cnt - f0); end
      checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL dirty_end_state: got busy,err=%b expected 00", {busy, err}); end
   endtask

   task automatic test_timeout();
      int r0, f0;
      r0 = rst_cnt; f0 = fv_cnt;
      miss_req = 1'b1; miss_addr = 32'h0000_7770; wb_dirty = 1'b1; wb_addr = 32'h0000_8880;
      step();
      miss_req = 1'b0;
      // WB_WAIT occupies the next 16 cycles
      for (int i = 0; i < 16; i++) step();
      checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL timeout_last_wait: got busy,err=%b expected 10", {busy, err}); end
      step();
      checks++; if ({busy, err} !== 2'b01) begin errors++; $display("FAIL timeout_err: got busy,err=%b expected 01", {busy, err}); end
      step();
      checks++; if (rst_cnt - r0 !== 0) begin errors++; $display("FAIL timeout_rstart_count: got %0d expected 0", rst_cnt - r0); end
      checks++; if (fv_cnt - f0 !== 0) begin errors++; $display("FAIL timeout_fv_count: got %0d expected 0", fv_cnt - f0); end
      miss_req = 1'b1; wb_dirty = 1'b0;
      step();
      miss_req = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b expected 0", err); end
   endtask

   task automatic test_empty_read();
      int f0;
      f0 = fv_cnt;
      // continues from the RD_REQ cycle left by test_timeout
      step();
      finish_mrd = 1'b1;
      step();
      finish_mrd = 1'b0;
      checks++; if ({busy, err, fill_valid} !== 3'b010) begin errors++; $display("FAIL empty_read_state: got busy,err,fv=%b expected 010", {busy, err, fill_valid}); end
      step();
      checks++; if (fv_cnt - f0 !== 0) begin errors++; $display("FAIL empty_read_fv_count: got %0d expected 0", fv_cnt - f0); end
      checks++; if (fill_data !== DATA_X) begin errors++; $display("FAIL fill_data_hold: got %h expected %h", fill_data, DATA_X); end
   endtask

   task automatic test_mid_reset();
      int r0, f0;
      miss_req = 1'b1; miss_addr = 32'h0000_abc4; wb_dirty = 1'b0;
      step();
      miss_req = 1'b0;
      step();
      rdat_m_valid = 1'b1; rdat_m_data = DATA_Y;
      step();
      rdat_m_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
      checks++; if (fill_data !== 128'd0) begin errors++; $display("FAIL mid_reset_fill_data: got %h expected 0", fill_data); end
      checks++; if ({err, fill_valid, wstart_rq, rstart_rq} !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags: got %b expected 0000", {err, fill_valid, wstart_rq, rstart_rq}); end
      checks++; if (rin_addr !== 32'd0) begin errors++; $display("FAIL mid_reset_rin_addr: got %h expected 0", rin_addr); end
      step(); step();
      rst_n = 1'b1;
      r0 = rst_cnt; f0 = fv_cnt;
      finish_mrd = 1'b1;
      step();
      finish_mrd = 1'b0;
      step(); step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_finish_busy: got %b expected 0", busy); end
      checks++; if (fv_cnt - f0 !== 0) begin errors++; $display("FAIL stray_finish_fv_count: got %0d expected 0", fv_cnt - f0); end
      checks++; if (rst_cnt - r0 !== 0) begin errors++; $display("FAIL stray_finish_rstart_count: got %0d expected 0", rst_cnt - r0); end
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_timeout();
      test_empty_read();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/line_xfer_ctrl.md
LINE_XFER_CTRL -- requirements
Module: line_xfer_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, giving the maximum cycles to wait for a bus-manager finish.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port miss_req, input, 1, line-transfer request; sampled only in IDLE.
REQ-005 SHALL have port miss_addr, input, 32, fill line address.
REQ-006 SHALL have port wb_dirty, input, 1, victim line needs writeback.
REQ-007 SHALL have port wb_addr, input, 32, victim line address.
REQ-008 SHALL have port wb_data, input, 128, victim line data.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port fill_valid, output, 1, one-cycle pulse; fill_data is valid when it is high.
REQ-011 SHALL have port fill_data, output, 128, last captured read line.
REQ-012 SHALL have port err, output, 1, sticky flag for a timeout or a finish with no read data.
REQ-013 SHALL have port wstart_rq, output, 1, write-manager start pulse.
REQ-014 SHALL have port win_addr, output, 32, write-manager address.
REQ-015 SHALL have port in_wdata, output, 128, write-manager data.
REQ-016 SHALL have port finish_wresp, input, 1, write response complete.
REQ-017 SHALL have port rstart_rq, output, 1, read-manager start pulse.
REQ-018 SHALL have port rin_addr, output, 32, read-manager address.
REQ-019 SHALL have port rdat_m_data, input, 128, read data from the read manager.
REQ-020 SHALL have port rdat_m_valid, input, 1, rdat_m_data is valid.
REQ-021 SHALL have port finish_mrd, input, 1, read transaction complete.

Function
REQ-022 SHALL implement the states IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT and DONE.
REQ-023 In IDLE with miss_req=1, the block SHALL latch miss_addr and wb_addr with bits [3:0] forced to 0, latch wb_data, and clear err.
- If wb_dirty=1, it SHALL go to WB_REQ.
- If wb_dirty=0, it SHALL go to RD_REQ.
REQ-024 miss_req SHALL be ignored in every state other than IDLE.
REQ-025 WB_REQ SHALL last exactly one cycle, assert wstart_rq=1, and then go to WB_WAIT.
REQ-026 win_addr and in_wdata SHALL show the latched values from WB_REQ until the next accepted miss_req.
REQ-027 In WB_WAIT, finish_wresp=1 SHALL move the block to RD_REQ.
REQ-028 RD_REQ SHALL last exactly one cycle, assert rstart_rq=1 with rin_addr set to the latched fill address, and then go to RD_WAIT.
REQ-029 In RD_WAIT, every cycle with rdat_m_valid=1 SHALL load fill_data from rdat_m_data, so the last beat wins.
REQ-030 In RD_WAIT, finish_mrd=1 SHALL move the block to DONE if at least one rdat_m_valid was seen, including a beat in the same cycle as finish_mrd.
REQ-031 In RD_WAIT, finish_mrd=1 with no rdat_m_valid seen SHALL set err=1 and return the block to IDLE without a fill_valid pulse.
REQ-032 DONE SHALL assert fill_valid=1 for exactly one cycle and then go to IDLE.
REQ-033 fill_data SHALL hold its value until the next rdat_m_valid.
REQ-034 A wait counter SHALL clear on entry to WB_WAIT and on entry to RD_WAIT, and increment every cycle spent in a wait state.
REQ-035 If the wait counter reaches TIMEOUT-1 without the expected finish, the block SHALL set err=1 and go to IDLE without a fill_valid pulse.
REQ-036 The wait counter width SHALL be clog2(TIMEOUT) and it SHALL never wrap.
REQ-037 When a finish arrives in the same cycle as the timeout, the finish SHALL take priority.
REQ-038 finish_wresp outside WB_WAIT and finish_mrd outside RD_WAIT SHALL be ignored.
REQ-039 wstart_rq, rstart_rq and fill_valid SHALL be driven from registers and never be high in the same cycle.
REQ-040 Latency with a clean victim SHALL be: miss_req in cycle 0, rstart_rq in cycle 1, and fill_valid one cycle after the cycle in which finish_mrd is sampled.

Reset
REQ-041 While rst_n=0, the block SHALL enter IDLE immediately, regardless of the clock.
REQ-042 While rst_n=0, all outputs, the latched data and the wait counter SHALL be 0.
REQ-043 A reset in the middle of a transfer SHALL abort it without issuing a further start pulse or a fill_valid pulse.

Verification
REQ-044 Clean miss: miss_req with miss_addr=32'h0000_1237 and wb_dirty=0 -> rstart_rq in cycle 1 with rin_addr=32'h0000_1230 and wstart_rq never high; then rdat_m_valid with data 128'hA5..A5 followed by finish_mrd -> exactly one fill_valid pulse with fill_data=128'hA5..A5.
REQ-045 Dirty miss: wb_addr=32'hdeadbeef, wb_data=128'h44444444_33333333_22222222_11111111 -> wstart_rq pulse with win_addr=32'hdeadbee0 and in_wdata equal to wb_data; finish_wresp after 7 cycles -> rstart_rq on the next cycle.
REQ-046 Timeout: TIMEOUT=16, no finish_wresp -> err=1 and busy=0 after 16 wait cycles, with no rstart_rq and no fill_valid; a following miss_req clears err.
REQ-047 Empty read: finish_mrd with no rdat_m_valid -> err=1, no fill_valid pulse, and a return to IDLE.
REQ-048 Mid-transfer reset: rst_n pulled low during RD_WAIT -> busy=0 and all outputs 0 at once; a stray finish_mrd after reset is released -> no fill_valid pulse.
REQ-049 Busy rejection: a second miss_req during WB_WAIT -> ignored, so exactly one wstart_rq pulse and one rstart_rq pulse occur in total.
